// File: rtl/scmp_bus_initiator.sv
// SC/MP-style bus initiator: turns a valid/ready request into an ADS_n address/flag
// strobe followed by an RD_n or WR_n strobe, with responder wait (hold_n) and a
// one-cycle completion pulse. All bus outputs come straight from registers.
module scmp_bus_initiator #(
    parameter int ADS_CYC = 1,
    parameter int STB_CYC = 2,
    parameter int REC_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [3:0]  req_flags,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [11:0] addr,
    output logic [7:0]  D_o,
    output logic        D_oe,
    input  logic [7:0]  D_i,
    input  logic        hold_n,
    output logic        ADS_n,
    output logic        RD_n,
    output logic        WR_n,
    output logic        busy
);

    if (ADS_CYC < 1 || ADS_CYC > 15 || STB_CYC < 1 || STB_CYC > 15 ||
        REC_CYC < 1 || REC_CYC > 15) begin : g_param_check
        $error("scmp_bus_initiator: ADS_CYC/STB_CYC/REC_CYC must be in 1..15");
    end

    // Phase counters count down to zero, so each phase loads its length minus one.
    localparam logic [3:0] ADS_LD = 4'(ADS_CYC - 1);
    localparam logic [3:0] STB_LD = 4'(STB_CYC - 1);
    localparam logic [3:0] REC_LD = 4'(REC_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        RECOV  = 3'd4
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        wr_q;
    logic [7:0]  wdata_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_rdata_q;
    logic [11:0] addr_q;
    logic [7:0]  D_o_q;
    logic        D_oe_q;
    logic        ADS_n_q;
    logic        RD_n_q;
    logic        WR_n_q;
    logic        busy_q;

    // Bus-cycle sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            wdata_q     <= 8'h00;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            addr_q      <= 12'h000;
            D_o_q       <= 8'h00;
            D_oe_q      <= 1'b0;
            ADS_n_q     <= 1'b1;
            RD_n_q      <= 1'b1;
            WR_n_q      <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        state_q     <= ADDR;
                        cnt_q       <= ADS_LD;
                        wr_q        <= req_wr;
                        wdata_q     <= req_wdata;
                        addr_q      <= req_addr[11:0];
                        D_o_q       <= {req_flags, req_addr[15:12]};
                        D_oe_q      <= 1'b1;
                        ADS_n_q     <= 1'b0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end else begin
                        // Covers the first cycle after reset release.
                        req_ready_q <= 1'b1;
                    end
                end
                ADDR: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= SETUP;
                        ADS_n_q <= 1'b1;
                        if (wr_q) begin
                            D_o_q <= wdata_q;
                        end else begin
                            D_oe_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                SETUP: begin
                    state_q <= STROBE;
                    cnt_q   <= STB_LD;
                    if (wr_q) begin
                        WR_n_q <= 1'b0;
                    end else begin
                        RD_n_q <= 1'b0;
                    end
                end
                STROBE: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (hold_n) begin
                        // Ending edge: responder is ready, close the strobe.
                        state_q     <= RECOV;
                        cnt_q       <= REC_LD;
                        RD_n_q      <= 1'b1;
                        WR_n_q      <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        if (!wr_q) begin
                            rsp_rdata_q <= D_i;
                        end
                    end
                    // hold_n low on the ending edge: stay one more cycle.
                end
                RECOV: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= IDLE;
                        D_oe_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign addr      = addr_q;
    assign D_o       = D_o_q;
    assign D_oe      = D_oe_q;
    assign ADS_n     = ADS_n_q;
    assign RD_n      = RD_n_q;
    assign WR_n      = WR_n_q;
    assign busy      = busy_q;

endmodule
